// File: rtl/riscv_dmem_lsu.sv
// riscv_dmem_lsu
// Load/store unit between the RV32I memory stage and a synchronous data
// memory whose read data arrives MEM_LATENCY cycles after the access strobe.
// One request is in flight at a time. Store data is replicated across byte
// lanes with matching byte enables. Load data is shifted down and sign- or
// zero-extended. Misaligned or illegal accesses are answered with an error
// and never reach the memory.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_req_*               request handshake (valid/ready), we, funct3, addr, wdata
//   o_rsp_valid/rdata/err one-cycle response strobe with extended load data
//   o_busy                unit is not idle
//   o_mem_*               memory strobe, write enable, word address, byte
//                         enables, lane-replicated write data
//   i_mem_rdata           memory read word
module riscv_dmem_lsu #(
  parameter int XLEN        = 32,
  parameter int ADDR_BIT    = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [2:0]          i_req_funct3,
  input  logic [XLEN-1:0]     i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_rsp_valid,
  output logic [XLEN-1:0]     o_rsp_rdata,
  output logic                o_rsp_err,
  output logic                o_busy,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_BIT-3:0] o_mem_addr,
  output logic [3:0]          o_mem_byte_sel,
  output logic [XLEN-1:0]     o_mem_wdata,
  input  logic [XLEN-1:0]     i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} lsuStateT;

  lsuStateT stateReg, stateNext;

  logic                weReg;
  logic [2:0]          funct3Reg;
  logic [1:0]          offsetReg;
  logic [3:0]          waitCntReg;
  logic [XLEN-1:0]     rdataReg;
  logic                errReg;
  logic                memWeReg;
  logic [ADDR_BIT-3:0] memAddrReg;
  logic [3:0]          memByteSelReg;
  logic [XLEN-1:0]     memWdataReg;

  logic                accept;
  logic                reqIllegal;
  logic                reqMisaligned;
  logic                reqErr;
  logic [3:0]          laneSel;
  logic [XLEN-1:0]     laneData;
  logic [XLEN-1:0]     shiftedWord;
  logic [XLEN-1:0]     loadData;

  // Address bits above the decoded memory window are deliberately ignored.
  logic unusedAddrBits;
  assign unusedAddrBits = ^i_req_addr[XLEN-1:ADDR_BIT];

  assign accept = i_req_valid && o_req_ready;

  // Request legality: funct3[1:0] encodes the access size for both loads
  // and stores, so alignment is checked on those two bits alone.
  always_comb begin
    if (i_req_we) begin
      reqIllegal = (i_req_funct3 > 3'd2);
    end else begin
      reqIllegal = (i_req_funct3 == 3'd3) || (i_req_funct3[2:1] == 2'b11);
    end
    case (i_req_funct3[1:0])
      2'd1:    reqMisaligned = i_req_addr[0];
      2'd2:    reqMisaligned = |i_req_addr[1:0];
      default: reqMisaligned = 1'b0;
    endcase
  end

  assign reqErr = reqIllegal || reqMisaligned;

  // Byte enables and lane replication; loads keep all four lanes enabled.
  always_comb begin
    laneSel  = 4'b1111;
    laneData = i_req_wdata;
    if (i_req_we) begin
      case (i_req_funct3[1:0])
        2'd0: begin
          laneSel  = 4'b0001 << i_req_addr[1:0];
          laneData = {4{i_req_wdata[7:0]}};
        end
        2'd1: begin
          laneSel  = i_req_addr[1] ? 4'b1100 : 4'b0011;
          laneData = {2{i_req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction from the returned word.
  assign shiftedWord = i_mem_rdata >> {offsetReg, 3'b000};

  always_comb begin
    case (funct3Reg)
      3'd0:    loadData = {{24{shiftedWord[7]}}, shiftedWord[7:0]};
      3'd1:    loadData = {{16{shiftedWord[15]}}, shiftedWord[15:0]};
      3'd2:    loadData = shiftedWord;
      3'd4:    loadData = {24'd0, shiftedWord[7:0]};
      3'd5:    loadData = {16'd0, shiftedWord[15:0]};
      default: loadData = '0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: begin
        if (i_req_valid) stateNext = reqErr ? RESP : ACCESS;
      end
      ACCESS: begin
        stateNext = weReg ? RESP : WAIT;
      end
      WAIT: begin
        if (waitCntReg == 4'd0) stateNext = RESP;
      end
      RESP: begin
        if (i_req_valid) stateNext = reqErr ? RESP : ACCESS;
        else             stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    o_req_ready = 1'b0;
    o_busy      = 1'b1;
    o_rsp_valid = 1'b0;
    o_mem_en    = 1'b0;
    case (stateReg)
      IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
      end
      ACCESS: o_mem_en = 1'b1;
      WAIT:   ;
      RESP: begin
        o_req_ready = 1'b1;
        o_rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers. Memory-side registers only update for accepted,
  // error-free requests, so they hold their last values otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      weReg         <= 1'b0;
      funct3Reg     <= 3'd0;
      offsetReg     <= 2'd0;
      waitCntReg    <= 4'd0;
      rdataReg      <= '0;
      errReg        <= 1'b0;
      memWeReg      <= 1'b0;
      memAddrReg    <= '0;
      memByteSelReg <= 4'd0;
      memWdataReg   <= '0;
    end else begin
      if (accept) begin
        weReg     <= i_req_we;
        funct3Reg <= i_req_funct3;
        offsetReg <= i_req_addr[1:0];
        errReg    <= reqErr;
        rdataReg  <= '0;
        if (!reqErr) begin
          memWeReg      <= i_req_we;
          memAddrReg    <= i_req_addr[ADDR_BIT-1:2];
          memByteSelReg <= laneSel;
          memWdataReg   <= laneData;
        end
      end
      if (stateReg == ACCESS) begin
        waitCntReg <= 4'(MEM_LATENCY - 1);
      end else if (stateReg == WAIT) begin
        waitCntReg <= waitCntReg - 4'd1;
        if (waitCntReg == 4'd0) rdataReg <= loadData;
      end
    end
  end

  assign o_rsp_rdata    = rdataReg;
  assign o_rsp_err      = errReg;
  assign o_mem_we       = memWeReg;
  assign o_mem_addr     = memAddrReg;
  assign o_mem_byte_sel = memByteSelReg;
  assign o_mem_wdata    = memWdataReg;

endmodule

// File: tb/tb_riscv_dmem_lsu.sv
// Testbench for riscv_dmem_lsu: three instances at memory latencies 1, 3, 4,
// each with its own synchronous memory. Expected values come from a
// byte-addressed reference memory and size/alignment rules.
module tb_riscv_dmem_lsu;

  localparam int NLANE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int curLane     = 0;

  logic        rst        [NLANE];
  logic        reqValid   [NLANE];
  logic        reqReady   [NLANE];
  logic        reqWe      [NLANE];
  logic [2:0]  reqFunct3  [NLANE];
  logic [31:0] reqAddr    [NLANE];
  logic [31:0] reqWdata   [NLANE];
  logic        rspValid   [NLANE];
  logic [31:0] rspRdata   [NLANE];
  logic        rspErr     [NLANE];
  logic        busy       [NLANE];
  logic        memEn      [NLANE];
  logic        memWe      [NLANE];
  logic [9:0]  memAddr    [NLANE];
  logic [3:0]  memByteSel [NLANE];
  logic [31:0] memWdata   [NLANE];
  logic [31:0] memRdata   [NLANE];
  logic        loadEn     [NLANE];
  logic [9:0]  loadAddr   [NLANE];
  logic [31:0] loadData   [NLANE];

  logic [7:0]  refBytes [NLANE][4096];

  function automatic int latOf(input int lane);
    return (lane == 0) ? 1 : (lane == 1) ? 3 : 4;
  endfunction

  for (genvar gi = 0; gi < NLANE; gi++) begin : gLane
    localparam int L = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
    logic [31:0] envMem [1024];
    logic [31:0] rdPipe [16];

    riscv_dmem_lsu #(.XLEN(32), .ADDR_BIT(12), .MEM_LATENCY(L)) dut (
      .i_clk          (clk),
      .i_rst          (rst[gi]),
      .i_req_valid    (reqValid[gi]),
      .o_req_ready    (reqReady[gi]),
      .i_req_we       (reqWe[gi]),
      .i_req_funct3   (reqFunct3[gi]),
      .i_req_addr     (reqAddr[gi]),
      .i_req_wdata    (reqWdata[gi]),
      .o_rsp_valid    (rspValid[gi]),
      .o_rsp_rdata    (rspRdata[gi]),
      .o_rsp_err      (rspErr[gi]),
      .o_busy         (busy[gi]),
      .o_mem_en       (memEn[gi]),
      .o_mem_we       (memWe[gi]),
      .o_mem_addr     (memAddr[gi]),
      .o_mem_byte_sel (memByteSel[gi]),
      .o_mem_wdata    (memWdata[gi]),
      .i_mem_rdata    (memRdata[gi])
    );

    // Synchronous memory: read data valid L cycles after the strobe cycle,
    // random junk on every other cycle.
    always @(posedge clk) begin
      if (loadEn[gi]) begin
        envMem[loadAddr[gi]] <= loadData[gi];
      end else if (memEn[gi] && memWe[gi]) begin
        for (int b = 0; b < 4; b++)
          if (memByteSel[gi][b]) envMem[memAddr[gi]][8*b +: 8] <= memWdata[gi][8*b +: 8];
      end
      rdPipe[0] <= (memEn[gi] && !memWe[gi]) ? envMem[memAddr[gi]] : $urandom;
      for (int s = 1; s < 16; s++) rdPipe[s] <= rdPipe[s-1];
    end
    assign memRdata[gi] = rdPipe[L-1];
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL lane%0d %s: got %h expected %h", curLane, tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Access size in bytes, 0 when funct3 is not a legal access.
  function automatic int sizeOf(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 0) ? 1 : (f3 == 1) ? 2 : (f3 == 2) ? 4 : 0;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic refErr(input logic we, input logic [2:0] f3, input int a);
    int s = sizeOf(we, f3);
    return (s == 0) || ((a % s) != 0);
  endfunction

  function automatic logic [31:0] refLoad(input int lane, input logic [2:0] f3, input int a);
    int s = sizeOf(1'b0, f3);
    longint v = 0;
    for (int i = 0; i < s; i++) v = v + (longint'(refBytes[lane][a+i]) << (8*i));
    if (!f3[2] && s < 4 && v[8*s-1]) v = v - (longint'(1) << (8*s));
    return v[31:0];
  endfunction

  function automatic logic [31:0] refLaneData(input int s, input logic [31:0] wd);
    if (s == 1) return {24'd0, wd[7:0]} * 32'h01010101;
    if (s == 2) return {16'd0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic doTxn(input int lane, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] got);
    int a = int'(addr[11:0]);
    int s = sizeOf(we, f3);
    logic e = refErr(we, f3, a);
    int expCyc = e ? 1 : (we ? 2 : latOf(lane) + 2);
    logic [31:0] expR = (e || we) ? 32'd0 : refLoad(lane, f3, a);
    logic [3:0] expSel = (!we || s == 4) ? 4'hF : 4'(((1 << s) - 1) << (a % 4));
    int enCnt = 0;
    int rspAt = 0;
    got = 32'd0;
    @(negedge clk);
    checkEq("idle_ready", reqReady[lane], 1);
    checkEq("idle_busy", busy[lane], 0);
    reqValid[lane] = 1'b1; reqWe[lane] = we; reqFunct3[lane] = f3;
    reqAddr[lane] = addr; reqWdata[lane] = wd;
    @(negedge clk);
    reqValid[lane] = 1'b0; reqWe[lane] = 1'($urandom); reqFunct3[lane] = 3'($urandom);
    reqAddr[lane] = $urandom; reqWdata[lane] = $urandom;
    for (int k = 1; k <= 24 && rspAt == 0; k++) begin
      if (k > 1) @(negedge clk);
      checkEq("busy", busy[lane], 1);
      if (memEn[lane]) begin
        enCnt++;
        checkEq("en_cycle", k, 1);
        checkEq("mem_we", memWe[lane], we);
        checkEq("mem_addr", memAddr[lane], a / 4);
        checkEq("byte_sel", memByteSel[lane], expSel);
        if (we) checkEq("mem_wdata", memWdata[lane], refLaneData(s, wd));
      end
      if (rspValid[lane]) begin
        rspAt = k;
        got = rspRdata[lane];
        checkEq("rsp_cycle", k, expCyc);
        checkEq("rsp_err", rspErr[lane], e);
        checkEq("rsp_rdata", rspRdata[lane], expR);
        checkEq("rsp_ready", reqReady[lane], 1);
      end
    end
    checkEq("rsp_seen", rspAt, expCyc);
    checkEq("en_count", enCnt, e ? 0 : 1);
    if (we && !e)
      for (int i = 0; i < s; i++) refBytes[lane][a+i] = wd[8*i +: 8];
    $display("lane%0d %s f3=%0d addr=%h wdata=%h -> err=%0d rdata=%h",
             lane, we ? "ST" : "LD", f3, addr, wd, e, got);
  endtask

  // SW then LW to the same word with valid held high throughout.
  task automatic backToBack(input int lane, input int a, input logic [31:0] wd);
    int L = latOf(lane);
    int enCnt = 0;
    int rspCnt = 0;
    @(negedge clk);
    reqValid[lane] = 1'b1; reqWe[lane] = 1'b1; reqFunct3[lane] = 3'd2;
    reqAddr[lane] = 32'(a); reqWdata[lane] = wd;
    @(negedge clk);
    for (int k = 1; k <= L + 7; k++) begin
      if (k > 1) @(negedge clk);
      if (memEn[lane]) begin
        enCnt++;
        if (enCnt == 1) begin
          checkEq("b2b_en1_cycle", k, 1);
          checkEq("b2b_en1_we", memWe[lane], 1);
        end else begin
          checkEq("b2b_en2_cycle", k, 3);
          checkEq("b2b_en2_we", memWe[lane], 0);
          checkEq("b2b_en2_addr", memAddr[lane], a / 4);
        end
      end
      if (rspValid[lane]) begin
        rspCnt++;
        if (rspCnt == 1) begin
          checkEq("b2b_rsp1_cycle", k, 2);
          checkEq("b2b_rsp1_rdata", rspRdata[lane], 0);
          checkEq("b2b_rsp1_ready", reqReady[lane], 1);
        end else begin
          checkEq("b2b_rsp2_cycle", k, L + 4);
          checkEq("b2b_rsp2_rdata", rspRdata[lane], wd);
          checkEq("b2b_rsp2_err", rspErr[lane], 0);
        end
      end
      if (k == 1) reqWe[lane] = 1'b0;
      if (k == 3) reqValid[lane] = 1'b0;
    end
    checkEq("b2b_en_count", enCnt, 2);
    checkEq("b2b_rsp_count", rspCnt, 2);
    for (int i = 0; i < 4; i++) refBytes[lane][a+i] = wd[8*i +: 8];
    $display("lane%0d B2B SW/LW addr=%h wdata=%h", lane, a, wd);
  endtask

  task automatic checkResetOutputs(input int lane);
    checkEq("rst_ready", reqReady[lane], 1);
    checkEq("rst_busy", busy[lane], 0);
    checkEq("rst_rsp_valid", rspValid[lane], 0);
    checkEq("rst_rsp_err", rspErr[lane], 0);
    checkEq("rst_rsp_rdata", rspRdata[lane], 0);
    checkEq("rst_mem_en", memEn[lane], 0);
    checkEq("rst_mem_we", memWe[lane], 0);
    checkEq("rst_mem_addr", memAddr[lane], 0);
    checkEq("rst_byte_sel", memByteSel[lane], 0);
    checkEq("rst_mem_wdata", memWdata[lane], 0);
  endtask

  // Reset asserted while a load sits in WAIT.
  task automatic resetInWait(input int lane, input int a);
    logic [31:0] got;
    @(negedge clk);
    reqValid[lane] = 1'b1; reqWe[lane] = 1'b0; reqFunct3[lane] = 3'd2; reqAddr[lane] = 32'(a);
    @(negedge clk);
    reqValid[lane] = 1'b0;
    @(negedge clk);
    checkEq("pre_rst_busy", busy[lane], 1);
    rst[lane] = 1'b1;
    #1;
    checkResetOutputs(lane);
    @(negedge clk);
    rst[lane] = 1'b0;
    for (int k = 0; k < latOf(lane) + 4; k++) begin
      @(negedge clk);
      checkEq("post_rst_rsp", rspValid[lane], 0);
      checkEq("post_rst_en", memEn[lane], 0);
    end
    $display("lane%0d RESET during WAIT addr=%h", lane, a);
    doTxn(lane, 1'b0, 3'd2, 32'(a), 32'd0, got);
  endtask

  task automatic randomTxns(input int lane, input int n);
    logic [31:0] got;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;
    int s;
    for (int i = 0; i < n; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        f3 = 3'($urandom_range(0, 4));
        if (f3 == 3'd3) f3 = 3'd5;
      end
      addr = $urandom;
      s = sizeOf(we, f3);
      if (s != 0 && $urandom_range(0, 3) != 0) addr = addr & ~32'(s - 1);
      doTxn(lane, we, f3, addr, $urandom, got);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    logic [31:0] w;
    for (int l = 0; l < NLANE; l++) begin
      rst[l] = 1'b1; reqValid[l] = 1'b0; reqWe[l] = 1'b0; reqFunct3[l] = 3'd0;
      reqAddr[l] = 32'd0; reqWdata[l] = 32'd0; loadEn[l] = 1'b0;
      loadAddr[l] = 10'd0; loadData[l] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int l = 0; l < NLANE; l++) begin
      curLane = l;
      checkResetOutputs(l);
    end
    for (int wi = 0; wi < 1024; wi++) begin
      @(negedge clk);
      for (int l = 0; l < NLANE; l++) begin
        w = (wi == 64) ? 32'h80112233 : (wi == 128) ? 32'hDEADBEEF : $urandom;
        loadEn[l] = 1'b1; loadAddr[l] = 10'(wi); loadData[l] = w;
        for (int b = 0; b < 4; b++) refBytes[l][4*wi+b] = w[8*b +: 8];
      end
    end
    @(negedge clk);
    for (int l = 0; l < NLANE; l++) loadEn[l] = 1'b0;
    @(negedge clk);
    for (int l = 0; l < NLANE; l++) rst[l] = 1'b0;

    for (int l = 0; l < NLANE; l++) begin
      curLane = l;
      doTxn(l, 1'b0, 3'd0, 32'h103, 32'd0, got);
      checkEq("lb_103", got, 32'hFFFFFF80);
      doTxn(l, 1'b0, 3'd4, 32'h103, 32'd0, got);
      checkEq("lbu_103", got, 32'h00000080);
      doTxn(l, 1'b0, 3'd1, 32'h102, 32'd0, got);
      checkEq("lh_102", got, 32'hFFFF8011);
      doTxn(l, 1'b0, 3'd2, 32'h200, 32'd0, got);
      checkEq("lw_200", got, 32'hDEADBEEF);
      doTxn(l, 1'b1, 3'd0, 32'h103, 32'h000000AB, got);
      doTxn(l, 1'b0, 3'd2, 32'h100, 32'd0, got);
      checkEq("lw_after_sb", got, 32'hAB112233);
      doTxn(l, 1'b0, 3'd1, 32'h101, 32'd0, got);
      doTxn(l, 1'b1, 3'd2, 32'h102, 32'h12345678, got);
      doTxn(l, 1'b0, 3'd6, 32'h104, 32'd0, got);
      doTxn(l, 1'b1, 3'd3, 32'h104, 32'h55AA55AA, got);
      randomTxns(l, 80);
      backToBack(l, 32'h300, $urandom);
      resetInWait(l, 32'h200);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/riscv_dmem_lsu.md
# riscv_dmem_lsu

Parametrised load/store unit between the pipelined RV32I core's memory stage and a synchronous data memory with configurable read latency. Accepts one request at a time over a valid/ready handshake. Derives byte enables and lane-replicated write data from funct3 and the address low bits, and sign- or zero-extends load data. Flags misaligned or illegal accesses without touching memory. Replaces the purely combinational dmem interface; supports memories slower than one cycle.

## Interface
Parameters:
- XLEN, 32, data width; only 32 is supported.
- ADDR_BIT, 12, byte-address bits decoded into the memory (DMEM_ADDR_BIT).
- MEM_LATENCY, 1, cycles from the o_mem_en cycle until i_mem_rdata is valid; legal range 1..15.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  unit can accept; high in IDLE and RESP.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- i_req_addr  in  XLEN  byte address.
- i_req_wdata  in  XLEN  store data, right-aligned.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  misaligned or illegal funct3; qualified by o_rsp_valid.
- o_busy  out  1  state != IDLE.
- o_mem_en  out  1  memory access strobe, one cycle per access.
- o_mem_we  out  1  write enable, qualified by o_mem_en.
- o_mem_addr  out  ADDR_BIT-2  word address = addr[ADDR_BIT-1:2].
- o_mem_byte_sel  out  4  byte enables.
- o_mem_wdata  out  XLEN  lane-replicated store data.
- i_mem_rdata  in  XLEN  memory read word.

## Operation
- States: IDLE, ACCESS, WAIT, RESP. Reset state: IDLE.
- A request is accepted on a clock edge where i_req_valid & o_req_ready. The unit registers we, funct3, addr[1:0], word address, and write data.
- Error check at accept:
  - Loads: funct3 3/6/7 are illegal.
  - Stores: funct3 > 2 are illegal.
  - LH/LHU/SH with addr[0]=1 are misaligned.
  - LW/SW with addr[1:0]≠0 are misaligned.
  - On error: go to RESP directly with err=1 and rdata=0; o_mem_en never asserts.
- ACCESS (one cycle): o_mem_en=1, plus o_mem_we, o_mem_addr, o_mem_byte_sel, o_mem_wdata.
  - Stores then go to RESP.
  - Loads go to WAIT with a 4-bit counter loaded to MEM_LATENCY-1.
- Store lanes:
  - SB: byte_sel = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: byte_sel = 0011 (addr[1]=0) or 1100, wdata = {2{wdata[15:0]}}.
  - SW: byte_sel = 1111, wdata unchanged.
  - Loads drive byte_sel = 1111 and we = 0.
- WAIT: the counter decrements each cycle. At count 0, i_mem_rdata is captured and the state moves to RESP.
- Load extract: the shifted word is rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- RESP (one cycle): o_rsp_valid=1.
  - A new request is accepted in the same cycle, giving back-to-back operation.
  - Otherwise the state returns to IDLE.
- o_mem_* hold their last values outside ACCESS; only o_mem_en gates them.

## Timing
- Accept edge ends cycle T.
- Store: ACCESS in T+1, o_rsp_valid in T+2.
- Load: ACCESS in T+1, WAIT in T+2..T+1+MEM_LATENCY, o_rsp_valid in T+2+MEM_LATENCY. With MEM_LATENCY=1 the response is in T+3.
- Error: o_rsp_valid in T+1.
- Maximum throughput is one store per 2 cycles and one load per MEM_LATENCY+2 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from i_req_* to any output.
- Reset values: state IDLE; o_req_ready=1; o_busy=0; o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0; o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_byte_sel=0, o_mem_wdata=0.
- i_rst asserted mid-operation, in any state, forces IDLE immediately. Any pending response is dropped, and an in-flight store is not reissued.
- i_req_valid in ACCESS/WAIT is ignored (ready=0); the requester must hold it.

## Test plan
- Store byte: SB, addr 0x103, wdata 0x000000AB. Expect:
  - o_mem_en in T+1 with we=1, addr 0x40, byte_sel 1000, wdata 0xABABABAB.
  - rsp_valid in T+2 with err=0, rdata=0.
- Load byte sign/zero, memory word 0x80112233 at 0x100, MEM_LATENCY=1:
  - LB 0x103 → rdata 0xFFFFFF80 in T+3.
  - LBU 0x103 → 0x00000080.
  - LH 0x102 → 0xFFFF8011.
- Misaligned: LH at 0x101 → rsp_valid in T+1 with err=1, rdata 0, and o_mem_en never high. SW at 0x102 behaves the same.
- Latency sweep: MEM_LATENCY=3, LW 0x200 with memory 0xDEADBEEF → o_mem_en in T+1, rsp_valid in T+5 with 0xDEADBEEF, busy high T+1..T+5.
- Back-to-back: SW then LW held valid continuously → second accept in the first's RESP cycle; exactly two o_mem_en pulses; responses in order.
- Reset in WAIT (MEM_LATENCY=4): assert i_rst in T+3 → next cycle IDLE, ready=1, no rsp_valid; a following LW completes normally.
